// File: rtl/switch_cell_dispatch.sv
// Packet-to-cell dispatcher: takes one descriptor at a time, streams its
// contiguous cells out of cell memory and forwards them to one egress port.
module switch_cell_dispatch #(
  parameter int CELL_AW     = 10,
  parameter int MAX_CELLS_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [1:0]             desc_port,
  input  logic [CELL_AW-1:0]     desc_addr,
  input  logic [MAX_CELLS_W-1:0] desc_cells,
  output logic                   mem_rd,
  output logic [CELL_AW-1:0]     mem_addr,
  input  logic [127:0]           mem_dout,
  output logic                   o_cell_fifo_wr,
  output logic [3:0]             o_cell_fifo_sel,
  output logic [127:0]           o_cell_fifo_din,
  output logic                   o_cell_first,
  output logic                   o_cell_last,
  input  logic [3:0]             o_cell_bp,
  output logic                   pkt_done,
  output logic [15:0]            drop_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             port_q, port_d;
  logic [CELL_AW-1:0]     addr_q, addr_d;
  logic [MAX_CELLS_W-1:0] count_q, count_d;
  logic                   firstPend_q, firstPend_d;
  logic [15:0]            drop_q, drop_d;

  logic                   wr_q, first_q, last_q;
  logic [1:0]             wrPort_q;

  logic accept;
  logic zeroDesc;
  logic cellGo;
  logic finalRead;
  logic wrOut;

  assign accept    = desc_valid && desc_ready;
  assign zeroDesc  = (desc_cells == '0);
  assign cellGo    = (state_q == SEND) && !o_cell_bp[port_q] && !rst;
  assign finalRead = cellGo && (count_q == MAX_CELLS_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !zeroDesc) state_d = SEND;
      SEND:    if (finalRead)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  always_comb begin
    desc_ready = (state_q == IDLE) && !rst;
    mem_rd     = cellGo;
    mem_addr   = rst ? '0 : addr_q;
  end

  always_comb begin
    port_d      = port_q;
    addr_d      = addr_q;
    count_d     = count_q;
    firstPend_d = firstPend_q;
    drop_d      = drop_q;
    if (accept) begin
      if (zeroDesc) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else begin
        port_d      = desc_port;
        addr_d      = desc_addr;
        count_d     = desc_cells;
        firstPend_d = 1'b1;
      end
    end else if (cellGo) begin
      addr_d      = addr_q + CELL_AW'(1);
      count_d     = count_q - MAX_CELLS_W'(1);
      firstPend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      firstPend_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      port_q      <= port_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      firstPend_q <= firstPend_d;
      drop_q      <= drop_d;
    end
  end

  // Write stage tracks the read issued one cycle earlier; backpressure is
  // not consulted here because the egress stage absorbs the in-flight cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      wrPort_q <= '0;
    end else begin
      wr_q     <= cellGo;
      first_q  <= cellGo && firstPend_q;
      last_q   <= finalRead;
      wrPort_q <= port_q;
    end
  end

  assign wrOut           = wr_q && !rst;
  assign o_cell_fifo_wr  = wrOut;
  assign o_cell_fifo_sel = wrOut ? (4'b0001 << wrPort_q) : 4'b0000;
  assign o_cell_fifo_din = wrOut ? mem_dout : '0;
  assign o_cell_first    = wrOut && first_q;
  assign o_cell_last     = wrOut && last_q;
  assign pkt_done        = wrOut && last_q;
  assign drop_cnt        = rst ? 16'h0000 : drop_q;

endmodule

// File: doc/switch_cell_dispatch.md
SWITCH_CELL_DISPATCH -- requirements
Module: switch_cell_dispatch

Interface
REQ-001 Parameter CELL_AW, default 10, cell-memory address width; addresses wrap modulo 2^CELL_AW.
REQ-002 Parameter MAX_CELLS_W, default 6, width of the descriptor cell count (1..63 cells per packet).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 desc_valid  input  1  packet descriptor present.
REQ-006 desc_ready  output  1  descriptor accepted when desc_valid and desc_ready are both high.
REQ-007 desc_port  input  2  destination egress port, 0..3.
REQ-008 desc_addr  input  CELL_AW  address of the packet's first cell.
REQ-009 desc_cells  input  MAX_CELLS_W  number of contiguous cells in the packet.
REQ-010 mem_rd  output  1  cell-memory read strobe.
REQ-011 mem_addr  output  CELL_AW  cell-memory read address.
REQ-012 mem_dout  input  128  read data, valid exactly 1 cycle after mem_rd.
REQ-013 o_cell_fifo_wr  output  1  cell write strobe to the egress stage.
REQ-014 o_cell_fifo_sel  output  4  one-hot port select, valid with o_cell_fifo_wr.
REQ-015 o_cell_fifo_din  output  128  cell data.
REQ-016 o_cell_first / o_cell_last  output  1 each  first/last cell of the packet.
REQ-017 o_cell_bp  input  4  per-port backpressure; bit p high means port p accepts no new cell.
REQ-018 pkt_done  output  1  one-cycle pulse with the write of a packet's last cell.
REQ-019 drop_cnt  output  16  count of zero-length descriptors discarded; saturates at 0xFFFF.

Function
REQ-020 FSM states are IDLE and SEND; desc_ready SHALL be high only in IDLE.
REQ-021 In IDLE, an accepted descriptor with desc_cells!=0 SHALL latch port, address and count, and the FSM SHALL move to SEND on the next cycle.
REQ-022 An accepted descriptor with desc_cells==0 SHALL be discarded; the FSM stays in IDLE and drop_cnt increments by 1 (saturating).
REQ-023 In SEND, each cycle with o_cell_bp[port]==0, the block SHALL assert mem_rd, drive mem_addr to the current address, then increment the address (wrapping) and decrement the remaining count.
REQ-024 In SEND, a cycle with o_cell_bp[port]==1 SHALL issue no read and SHALL leave the address and count unchanged.
REQ-025 Only o_cell_bp[port] SHALL be evaluated; backpressure on other ports SHALL have no effect.
REQ-026 The read of the final cell SHALL return the FSM to IDLE on the next cycle, so the next descriptor can be accepted then.
REQ-027 For each read, o_cell_fifo_wr SHALL assert exactly 1 cycle later, with o_cell_fifo_din=mem_dout and o_cell_fifo_sel=1<<port.
REQ-028 o_cell_first SHALL be high with the first cell of the packet; o_cell_last and pkt_done SHALL be high with the last cell; for a 1-cell packet, first and last SHALL both be high.
REQ-029 Latency from descriptor acceptance (cycle N) to the first o_cell_fifo_wr SHALL be N+2 when bp is low.
REQ-030 Sustained throughput SHALL be 1 cell/cycle with bp low, with no gap between cells of one packet.
REQ-031 When o_cell_fifo_wr is low, o_cell_fifo_sel, o_cell_first, o_cell_last and pkt_done SHALL be 0.
REQ-032 Backpressure that rises in the cycle of a read SHALL NOT suppress that read's write; the downstream stage absorbs one in-flight cell.

Reset
REQ-033 While rst is high, the FSM SHALL be IDLE; desc_ready=0, mem_rd=0, mem_addr=0, o_cell_fifo_wr=0, o_cell_fifo_sel=0, o_cell_fifo_din=0, first/last=0, pkt_done=0 and drop_cnt=0.
REQ-034 Reset asserted mid-packet SHALL abort the packet, and the in-flight write SHALL be suppressed, in the cycle after rst is sampled.
REQ-035 desc_ready SHALL rise in the first cycle after rst is deasserted.

Verification
REQ-036 Descriptor (port 2, addr 0x010, cells 3) with bp=0: mem_rd at N+1..N+3 with addr 0x010..0x012; wr at N+2..N+4; sel=0100; first at N+2; last and pkt_done at N+4.
REQ-037 Wrap: addr 0x3FE, cells 4: read addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-038 Port-1 packet of 4 cells with o_cell_bp[1] high for 3 cycles after the second read: exactly 4 writes, no duplicate or skipped address; o_cell_bp[0] toggling during the packet has no effect.
REQ-039 Three zero-length descriptors, then a 1-cell descriptor: drop_cnt=3; a single write with first=last=pkt_done=1.
REQ-040 Back-to-back descriptors (2 cells to port 0, then 2 cells to port 3): the second is accepted the cycle after the first packet's final read; sel changes 0001 to 0011-free 1000 with no overlap.
REQ-041 rst pulsed during the 2nd of 5 cells: no o_cell_fifo_wr from the cycle after rst is sampled; desc_ready=1 after release; a new packet then completes normally.
